// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial path (transmit and recieve).
package spart_pkg;

    // Transmitter frame states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Oversample pulses per bit and data bits per frame
    localparam int SPART_OSR    = 16;
    localparam int SPART_DATA_W = 8;

    // Processor bus direction encodings
    localparam logic IORW_WRITE = 1'b0;
    localparam logic IORW_READ  = 1'b1;

endpackage

// File: rtl/transmit.sv
// SPART transmitter: single-entry holding buffer feeding a start/8-data/stop
// serialiser, MSB first, each bit lasting OSR pulses of the shared b_en.
module transmit
    import spart_pkg::*;
#(
    parameter int DATA_W = SPART_DATA_W,
    parameter int OSR    = SPART_OSR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_en,
    input  logic              i_iocs,
    input  logic              i_iorw,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_tx,
    output logic              o_tbr,
    output logic              o_busy
);

    localparam int OS_W  = $clog2(OSR);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OSR - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         nxt_state;
    logic [DATA_W-1:0] hold;
    logic              hold_vld;
    logic [DATA_W-1:0] shft;
    logic [DATA_W-1:0] nxt_shft;
    logic [OS_W-1:0]   os_cnt;
    logic [OS_W-1:0]   nxt_os_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  nxt_bit_cnt;
    logic              tx_q;
    logic              nxt_tx;
    logic              busy_q;
    logic              load;
    logic              accept;
    logic              bit_end;

    // A write only lands when the holding buffer is empty; reads never do anything
    assign accept  = i_iocs && (i_iorw == IORW_WRITE) && !hold_vld;
    assign bit_end = b_en && (os_cnt == OS_LAST);

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_tbr  = !hold_vld;

    // Next-state, counter and shifter logic; line value is derived from the next state
    always_comb begin
        nxt_state   = state;
        nxt_shft    = shft;
        nxt_os_cnt  = os_cnt;
        nxt_bit_cnt = bit_cnt;
        load        = 1'b0;
        nxt_tx      = 1'b1;

        case (state)
            IDLE: begin
                if (hold_vld) begin
                    load        = 1'b1;
                    nxt_shft    = hold;
                    nxt_os_cnt  = '0;
                    nxt_bit_cnt = '0;
                    nxt_state   = START;
                end
            end
            START: begin
                if (b_en) begin
                    nxt_os_cnt = bit_end ? '0 : os_cnt + OS_W'(1);
                end
                if (bit_end) begin
                    nxt_state = DATA;
                end
            end
            DATA: begin
                if (b_en) begin
                    nxt_os_cnt = bit_end ? '0 : os_cnt + OS_W'(1);
                end
                if (bit_end) begin
                    nxt_shft    = {shft[DATA_W-2:0], 1'b0};
                    nxt_bit_cnt = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        nxt_state = STOP;
                    end
                end
            end
            STOP: begin
                if (b_en) begin
                    nxt_os_cnt = bit_end ? '0 : os_cnt + OS_W'(1);
                end
                if (bit_end) begin
                    if (hold_vld) begin
                        load        = 1'b1;
                        nxt_shft    = hold;
                        nxt_os_cnt  = '0;
                        nxt_bit_cnt = '0;
                        nxt_state   = START;
                    end else begin
                        nxt_state = IDLE;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        case (nxt_state)
            START:   nxt_tx = 1'b0;
            DATA:    nxt_tx = nxt_shft[DATA_W-1];
            default: nxt_tx = 1'b1;
        endcase
    end

    // Frame state, shifter, counters and registered line/busy outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shft    <= '0;
            os_cnt  <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= nxt_state;
            shft    <= nxt_shft;
            os_cnt  <= nxt_os_cnt;
            bit_cnt <= nxt_bit_cnt;
            tx_q    <= nxt_tx;
            busy_q  <= (nxt_state != IDLE);
        end
    end

    // Holding buffer: a load into the shifter empties it, an accepted write fills it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else begin
            if (accept) begin
                hold <= i_data;
            end
            if (load) begin
                hold_vld <= 1'b0;
            end else if (accept) begin
                hold_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit: decodes o_tx frames by counting b_en pulses.
module tb_transmit;
    import spart_pkg::*;

    logic       clk;
    logic       rst;
    logic       b_en;
    logic       i_iocs;
    logic       i_iorw;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tbr;
    logic       o_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_data;
    logic       rx_ok;
    logic       rx_tbr;
    logic       rx_busy;

    transmit #(.DATA_W(8), .OSR(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .b_en   (b_en),
        .i_iocs (i_iocs),
        .i_iorw (i_iorw),
        .i_data (i_data),
        .o_tx   (o_tx),
        .o_tbr  (o_tbr),
        .o_busy (o_busy)
    );

    // 10 time-unit system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample enable on every other clock, changed just after the rising edge
    initial begin
        b_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            b_en = ~b_en;
        end
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus write: call at a falling edge; the next rising edge captures it
    task automatic bus_write(input logic [7:0] d);
        i_iocs = 1'b1;
        i_iorw = IORW_WRITE;
        i_data = d;
        @(negedge clk);
        i_iocs = 1'b0;
        i_iorw = IORW_WRITE;
    endtask

    // Waits for a start bit, then samples 10 bits of 16 b_en pulses each
    task automatic get_frame(input int max_wait, output logic [7:0] data, output logic framing_ok,
                             output logic start_tbr, output logic start_busy);
        int w;
        int cnt;
        logic [9:0] bits;
        logic v;
        framing_ok = 1'b1;
        bits       = '0;
        w          = 0;
        do begin
            @(negedge clk);
            w++;
        end while (o_tx !== 1'b0 && w < max_wait);
        if (o_tx !== 1'b0) begin
            data       = '0;
            framing_ok = 1'b0;
            start_tbr  = 1'b0;
            start_busy = 1'b0;
            return;
        end
        start_tbr  = o_tbr;
        start_busy = o_busy;
        for (int b = 0; b < 10; b++) begin
            if (b > 0) @(negedge clk);
            v          = o_tx;
            bits[9-b]  = v;
            cnt        = 0;
            while (1) begin
                if (o_tx !== v) framing_ok = 1'b0;
                if (b_en) cnt++;
                if (cnt == 16) break;
                @(negedge clk);
            end
        end
        if (bits[9] !== 1'b0 || bits[0] !== 1'b1) framing_ok = 1'b0;
        data = bits[8:1];
    endtask

    // Watches the line for n cycles and reports whether it ever left idle
    task automatic watch_idle(input int n, output logic saw_activity);
        saw_activity = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_tbr !== 1'b1 || o_busy !== 1'b0) saw_activity = 1'b1;
        end
    endtask

    task automatic applyStimulus();
        logic activity;
        int   cnt;
        int   w;
        logic [7:0] r;

        // Reset state
        rst    = 1'b0;
        i_iocs = 1'b0;
        i_iorw = 1'b0;
        i_data = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", o_tx, 1);
        checkOutput("reset_tbr", o_tbr, 1);
        checkOutput("reset_busy", o_busy, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0xA5 with write timing
        bus_write(8'hA5);
        checkOutput("a5_tbr_after_write", o_tbr, 0);
        checkOutput("a5_tx_before_load", o_tx, 1);
        checkOutput("a5_busy_before_load", o_busy, 0);
        get_frame(1, rx_data, rx_ok, rx_tbr, rx_busy);
        checkOutput("a5_start_next_edge", rx_ok, 1);
        checkOutput("a5_tbr_at_load", rx_tbr, 1);
        checkOutput("a5_busy_at_load", rx_busy, 1);
        checkOutput("a5_data", rx_data, 8'hA5);
        @(negedge clk);
        checkOutput("a5_idle_tx", o_tx, 1);
        checkOutput("a5_idle_busy", o_busy, 0);

        // Back-to-back 0x3C then 0xC3
        fork
            begin
                get_frame(100, rx_data, rx_ok, rx_tbr, rx_busy);
                checkOutput("b2b_3c_framing", rx_ok, 1);
                checkOutput("b2b_3c_data", rx_data, 8'h3C);
                checkOutput("b2b_tbr_low_at_stop_end", o_tbr, 0);
                get_frame(1, rx_data, rx_ok, rx_tbr, rx_busy);
                checkOutput("b2b_c3_no_gap", rx_ok, 1);
                checkOutput("b2b_c3_data", rx_data, 8'hC3);
                checkOutput("b2b_tbr_after_reload", rx_tbr, 1);
            end
            begin
                bus_write(8'h3C);
                @(negedge clk);
                checkOutput("b2b_tbr_back_high", o_tbr, 1);
                bus_write(8'hC3);
                checkOutput("b2b_tbr_after_c3_write", o_tbr, 0);
            end
        join

        // Write while the buffer is full is dropped
        fork
            begin
                get_frame(100, rx_data, rx_ok, rx_tbr, rx_busy);
                checkOutput("full_11_data", rx_data, 8'h11);
                get_frame(1, rx_data, rx_ok, rx_tbr, rx_busy);
                checkOutput("full_22_framing", rx_ok, 1);
                checkOutput("full_22_data", rx_data, 8'h22);
            end
            begin
                bus_write(8'h11);
                @(negedge clk);
                bus_write(8'h22);
                checkOutput("full_tbr_low", o_tbr, 0);
                bus_write(8'hFF);
            end
        join
        watch_idle(200, activity);
        checkOutput("full_ff_dropped_idle", activity, 0);

        // Reset in the middle of data bit 4 of 0xA5 (line low there)
        bus_write(8'hA5);
        w = 0;
        while (o_tx !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("rst_frame_started", o_tx, 0);
        cnt = 0;
        w   = 0;
        while (cnt < 88 && w < 400) begin
            if (b_en) cnt++;
            @(negedge clk);
            w++;
        end
        checkOutput("rst_pre_tx_bit4", o_tx, 0);
        checkOutput("rst_pre_busy", o_busy, 1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_tx", o_tx, 1);
        checkOutput("rst_mid_tbr", o_tbr, 1);
        checkOutput("rst_mid_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_write(8'h01);
        get_frame(10, rx_data, rx_ok, rx_tbr, rx_busy);
        checkOutput("rst_after_framing", rx_ok, 1);
        checkOutput("rst_after_data", rx_data, 8'h01);
        @(negedge clk);

        // Read cycle must not start a frame
        i_iocs = 1'b1;
        i_iorw = IORW_READ;
        i_data = 8'h55;
        @(negedge clk);
        i_iocs = 1'b0;
        i_iorw = IORW_WRITE;
        watch_idle(100, activity);
        checkOutput("read_ignored", activity, 0);

        // 100 random bytes
        for (int i = 0; i < 100; i++) begin
            r = 8'($urandom_range(0, 255));
            bus_write(r);
            get_frame(10, rx_data, rx_ok, rx_tbr, rx_busy);
            checkOutput($sformatf("rand_%0d", i), {23'd0, rx_ok, rx_data}, {23'd0, 1'b1, r});
        end
    endtask

    initial begin
        applyStimulus();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transmit.md
# transmit

- Serial transmitter for the SPART/UART path; the upstream counterpart of `recieve`. Its `o_tx` drives the line that a `recieve` instance samples.
- Accepts bytes from the processor bus through a single-entry holding buffer and serialises them into frames.
- Frame format: one start bit (0), 8 data bits MSB-first, one stop bit (1).
- Bit timing comes from the shared `brg` 16x oversample enable `b_en`; every bit lasts exactly 16 `b_en` pulses, which matches the receiver's framing.

## Interface
- `DATA_W`, default 8: data bits per frame.
- `OSR`, default 16: `b_en` pulses per bit.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `b_en` input 1: single-cycle oversample enable from `brg`.
- `i_iocs` input 1: chip select for this block.
- `i_iorw` input 1: 0 = write, 1 = read. Reads are ignored.
- `i_data` input `DATA_W`: byte to transmit.
- `o_tx` output 1: serial line, registered. Idles high.
- `o_tbr` output 1: transmit buffer ready; high when the holding buffer is empty.
- `o_busy` output 1: high while a frame is on the line (any state except IDLE).

## Operation
- Storage:
  - Holding register `hold[DATA_W-1:0]` plus `hold_vld`.
  - Shift register `shft[DATA_W-1:0]`.
  - 4-bit oversample counter `os_cnt`.
  - 3-bit bit counter `bit_cnt`.
- Write accept: `i_iocs && !i_iorw && o_tbr` at a clock edge loads `hold <= i_data` and sets `hold_vld`.
  - A write while `o_tbr=0` is dropped; the pending byte is never overwritten.
  - Reads (`i_iorw=1`) have no effect.
- `o_tbr = !hold_vld`, taken directly from the register.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: `o_tx=1`. If `hold_vld`, move `hold` to `shft`, clear `hold_vld`, zero `os_cnt` and `bit_cnt`, and go to START.
  - START: `o_tx=0`. Each `b_en` increments `os_cnt`. A `b_en` with `os_cnt==OSR-1` wraps `os_cnt` to 0 and goes to DATA.
  - DATA: `o_tx=shft[DATA_W-1]`. A `b_en` with `os_cnt==OSR-1` shifts `shft` left by 1 and increments `bit_cnt`. It goes to STOP once `bit_cnt==DATA_W-1` and that bit completes.
  - STOP: `o_tx=1`. At bit end (16th `b_en`), if `hold_vld`, load the next byte and go straight to START with no idle cycle. Otherwise go to IDLE.
- A write to `hold` on the same edge that a load empties it cannot happen, because `o_tbr` was 0 during that cycle.
- `b_en` is ignored in IDLE; `os_cnt` holds at 0.
- Reset (asserted at any time, including mid-frame):
  - `o_tx=1`, `o_tbr=1`, `o_busy=0`.
  - FSM goes to IDLE; `hold_vld`, `shft`, `os_cnt` and `bit_cnt` go to 0.
  - The frame in progress is abandoned with no stop bit.

## Timing
- Write captured at edge N. `o_tbr` falls after edge N.
- At edge N+1: shifter loaded, `o_tx` falls, `o_busy` rises, and `o_tbr` is high again.
- Start bit length = time from entering START to its 16th `b_en`, so the first bit is up to one `b_en` period plus 16 pulses. Every following bit is exactly 16 `b_en` pulses.
- Frame = 10 bits. Back-to-back frames have zero extra idle time.
- Line and status outputs (`o_tx`, `o_tbr`, `o_busy`) are glitch-free: all come from registers or a single register inversion.

## Structure
- Shared package `spart_pkg` holds:
  - `tx_state_t` enum: IDLE, START, DATA, STOP.
  - Constants `SPART_OSR=16` and `SPART_DATA_W=8`, which `recieve` also imports.
  - Bus encodings `IORW_WRITE=1'b0` and `IORW_READ=1'b1`.
- There is no sub-module. `brg` is instantiated at the SPART top level and shared with `recieve`.

## Test plan
- Reset, then write 0xA5 with `brg` divisor 0x028B:
  - `o_tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 16 `b_en`.
  - A loopback `recieve` reports `o_data=0xA5`.
- Write 0x3C, then 0xC3 as soon as `o_tbr` returns high:
  - Both frames are sent back to back with no idle gap.
  - `o_tbr` stays low from the 0xC3 write until the 0x3C stop bit ends.
- While the holding buffer is full, write 0xFF:
  - The write is ignored; the transmitted data remains the earlier pending byte.
- Assert `rst` low in the middle of data bit 4:
  - `o_tx` goes to 1 immediately, `o_tbr=1`, `o_busy=0`.
  - After release, a write of 0x01 transmits cleanly.
- Issue a read cycle (`i_iocs=1`, `i_iorw=1`) with `i_data=0x55`:
  - No frame starts, `o_tbr` stays 1, `o_tx` stays 1.
- Send 100 random bytes looped back into `recieve`:
  - Every received byte matches the transmitted byte.
